mux5_rr_ctrl: RTL and testbench
===============================

// Module: mux5_rr_ctrl
// PURPOSE
//  Upstream controller for the 5-way 8-bit selector mux5_8a. Arbitrates five request lines round-robin.
//  Drives the mux sel input, then captures the selected mux output into a registered result.
//  Presents the result downstream through a valid/ready handshake.
//  Sits between the request sources (in0..in4 producers) and the consumer of the muxed byte.
// PARAMETERS
//  WIDTH   8  data width of mux output / result
//  N_SRC   5  number of sources; fixed by mux5_8a, not for override
//  SEL_W   3  width of sel; values 5..7 are never driven
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  req        in   5      level request per source; bit i = in<i> has data
//  mux_out    in   WIDTH  combinational output of mux5_8a
//  sel        out  SEL_W  registered select to mux5_8a
//  ack        out  5      one-hot, one-cycle pulse: source i consumed
//  out_data   out  WIDTH  captured byte
//  out_src    out  SEL_W  source index of out_data
//  out_valid  out  1      out_data/out_src valid
//  out_ready  in   1      downstream accepts when out_valid & out_ready
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, ptr=0, sel=0, ack=0, out_data=0, out_src=0, out_valid=0.
//  Reset mid-operation: same values next cycle; a pending result is dropped. Any ack already issued stands.
//  ptr = highest-priority index; search order ptr, ptr+1, ... wrapping 4->0 (mod 5, never 5..7).
//  FSM states:
//   IDLE:   if |req: grant = first set bit from ptr; sel<=grant; ->SELECT. Else stay, sel holds.
//   SELECT: mux settled on sel. out_data<=mux_out; out_src<=sel; out_valid<=1.
//           ack[sel]=1 for this cycle only; ->HOLD. Capture happens even if req[sel] dropped.
//   HOLD:   out_valid=1; out_data/out_src stable while !out_ready.
//           On out_valid&out_ready: out_valid<=0; ptr<=(out_src==4)?0:out_src+1; ->IDLE.
//  Latency: req seen in IDLE -> out_valid high 2 cycles later.
//  Throughput: 1 result per 3 cycles with out_ready tied high.
//  sel changes only on the IDLE->SELECT transition, so mux_out is stable for the capture edge.
//  req changes during SELECT/HOLD are ignored until the next IDLE; no request is lost if held high.
//  Simultaneous reqs: exactly one grant per transaction; others wait. Rotating ptr bounds wait to 4 transactions.
//  Unused state encodings -> IDLE.
// STRUCTURE
//  mux5_pkg: localparams N_SRC=5, SEL_W=3, WIDTH=8; state codes ST_IDLE, ST_SELECT, ST_HOLD.
//  Also holds function next_idx(idx) = mod-5 increment.
//  Sub-module rr_pick5: combinational; (req[4:0], ptr[2:0]) -> (any, grant[2:0]); rotate-then-priority-encode.
//  Top: FSM + ptr/sel/out registers + ack decode. Bench instantiates mux5_rr_ctrl driving a real mux5_8a.
// TESTING (mux inputs in0..in4 = 2,4,8,16,32; out_ready=1 unless stated)
//  1. Reset, req=00100 -> sel=2 in SELECT; ack=00100 for one cycle.
//     out_valid, out_data=8, out_src=2 two cycles after req.
//  2. req=11111 held -> out_data sequence 2,4,8,16,32,2; out_src 0,1,2,3,4,0 (wrap).
//     One result every 3 cycles.
//  3. req=10001, ptr=0 -> grants 0 then 4 then 0. Reaching 4 only via wrap check: 4->0 never passes 5..7.
//  4. Backpressure: req=01000, out_ready=0 for 5 cycles.
//     out_valid=1, out_data=16, out_src=3 stable all 5 cycles; ack pulses once.
//     Accept on out_ready=1, then back to IDLE.
//  5. Reset in HOLD with out_valid=1 -> next cycle out_valid=0, sel=0, out_data=0, ptr=0.
//     req=00010 afterwards yields out_data=4.
//  6. req=00001 pulsed for IDLE cycle only, dropped in SELECT -> out_data=2 still delivered.
//     Next IDLE with req=0 stays idle, out_valid=0.

Source files
------------

// File: rtl/mux5_pkg.sv
// Shared constants, FSM state type and the mod-5 index helper for the
// five-source round-robin controller in front of mux5_8a.
package mux5_pkg;

    localparam int unsigned N_SRC = 5;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_HOLD
    } state_t;

    // Wraps 4 -> 0 so a source index never reaches the unused codes 5..7.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        if (idx >= SEL_W'(N_SRC - 1))
            return '0;
        else
            return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr, searching upward and wrapping modulo 5.
module rr_pick5
    import mux5_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] grant
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        any   = 1'b0;
        grant = '0;
        // An out-of-range pointer cannot occur; fall back to source 0 if it does.
        idx   = (ptr < SEL_W'(N_SRC)) ? ptr : '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/mux5_rr_ctrl.sv
// Round-robin controller for mux5_8a: grants one source, drives sel, captures
// the settled mux output and offers it downstream over valid/ready.
module mux5_rr_ctrl #(
    parameter int unsigned WIDTH = mux5_pkg::WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [mux5_pkg::N_SRC-1:0] req,
    input  logic [WIDTH-1:0]           mux_out,
    output logic [mux5_pkg::SEL_W-1:0] sel,
    output logic [mux5_pkg::N_SRC-1:0] ack,
    output logic [WIDTH-1:0]           out_data,
    output logic [mux5_pkg::SEL_W-1:0] out_src,
    output logic                       out_valid,
    input  logic                       out_ready
);

    import mux5_pkg::*;

    state_t           state;
    state_t           state_nx;
    logic [SEL_W-1:0] ptr;
    logic             any;
    logic [SEL_W-1:0] grant;
    logic             accept;

    rr_pick5 u_pick (
        .req   (req),
        .ptr   (ptr),
        .any   (any),
        .grant (grant)
    );

    assign accept = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ack      = '0;
        case (state)
            ST_IDLE: begin
                if (any)
                    state_nx = ST_SELECT;
            end
            ST_SELECT: begin
                ack[sel] = 1'b1;
                state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // sel moves only on IDLE->SELECT, so mux_out has a full cycle to settle before capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            sel       <= '0;
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any)
                        sel <= grant;
                end
                ST_SELECT: begin
                    out_data  <= mux_out;
                    out_src   <= sel;
                    out_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        ptr       <= next_idx(out_src);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux5_rr_ctrl.sv
// Scoreboard bench for mux5_rr_ctrl driving a behavioural mux5_8a
// whose inputs in0..in4 are 2,4,8,16,32.
module tb_mux5_rr_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] src;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [7:0] mux_out;
    logic [2:0] sel;
    logic [4:0] ack;
    logic [7:0] out_data;
    logic [2:0] out_src;
    logic       out_valid;
    logic       out_ready;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic sel_bad  = 1'b0;

    always #5 clk = ~clk;

    mux5_rr_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mux_out   (mux_out),
        .sel       (sel),
        .ack       (ack),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always_comb begin
        case (sel)
            3'd0:    mux_out = 8'd2;
            3'd1:    mux_out = 8'd4;
            3'd2:    mux_out = 8'd8;
            3'd3:    mux_out = 8'd16;
            3'd4:    mux_out = 8'd32;
            default: mux_out = 8'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per accepted transfer.
    always @(negedge clk) begin
        exp_t e;
        if (sel > 3'd4)
            sel_bad = 1'b1;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=data%0d/src%0d expected=none", out_data, out_src);
            end else begin
                e = q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e.data));
                chk("sb_src", 32'(out_src), 32'(e.src));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq_data [6];
        logic [2:0] seq_src  [6];
        seq_data = '{8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd2};
        seq_src  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

        rst = 1'b1; req = '0; out_ready = 1'b1;
        tick(2);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_src", 32'(out_src), 0);
        rst = 1'b0;

        // 1: single request from source 2
        req = 5'b00100;
        push(8'd8, 3'd2);
        tick(1);
        chk("t1_sel", 32'(sel), 2);
        chk("t1_ack", 32'(ack), 32'b00100);
        req = '0;
        tick(1);
        chk("t1_ack_off", 32'(ack), 0);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_data", 32'(out_data), 8);
        chk("t1_src", 32'(out_src), 2);
        tick(1);
        chk("t1_idle", 32'(out_valid), 0);

        // 2: all sources held, full rotation with wrap, one result per 3 cycles
        rst = 1'b1; tick(1); rst = 1'b0;
        req = 5'b11111;
        for (int i = 0; i < 6; i++) push(seq_data[i], seq_src[i]);
        tick(2);
        chk("t2_valid0", 32'(out_valid), 1);
        chk("t2_src0", 32'(out_src), 32'(seq_src[0]));
        for (int k = 1; k < 6; k++) begin
            tick(3);
            chk("t2_valid", 32'(out_valid), 1);
            chk("t2_src", 32'(out_src), 32'(seq_src[k]));
            chk("t2_data", 32'(out_data), 32'(seq_data[k]));
        end
        req = '0;
        tick(1);
        chk("t2_idle", 32'(out_valid), 0);
        tick(1);
        chk("t2_stay_idle", 32'(out_valid), 0);

        // 3: sources 0 and 4 alternate through the wrap
        rst = 1'b1; tick(1); rst = 1'b0;
        req = 5'b10001;
        push(8'd2, 3'd0); push(8'd32, 3'd4); push(8'd2, 3'd0);
        tick(2);
        chk("t3_src_a", 32'(out_src), 0);
        tick(3);
        chk("t3_src_b", 32'(out_src), 4);
        tick(3);
        chk("t3_src_c", 32'(out_src), 0);
        req = '0;
        tick(1);

        // 4: backpressure holds the result stable
        req = 5'b01000; out_ready = 1'b0;
        push(8'd16, 3'd3);
        tick(1);
        chk("t4_ack", 32'(ack), 32'b01000);
        req = '0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(out_valid), 1);
            chk("t4_hold_data", 32'(out_data), 16);
            chk("t4_hold_src", 32'(out_src), 3);
            chk("t4_hold_ack", 32'(ack), 0);
            if (i != 4) tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        chk("t4_released", 32'(out_valid), 0);

        // 5: reset while holding drops the pending result
        req = 5'b00010; out_ready = 1'b0;
        tick(1);
        req = '0;
        tick(1);
        chk("t5_pre_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_sel", 32'(sel), 0);
        chk("t5_data", 32'(out_data), 0);
        out_ready = 1'b1;
        req = 5'b00010;
        push(8'd4, 3'd1);
        tick(1);
        chk("t5_sel_after", 32'(sel), 1);
        req = '0;
        tick(1);
        chk("t5_data_after", 32'(out_data), 4);
        tick(1);
        chk("t5_idle", 32'(out_valid), 0);

        // 6: request dropped during SELECT is still delivered
        req = 5'b00001;
        push(8'd2, 3'd0);
        tick(1);
        chk("t6_sel", 32'(sel), 0);
        chk("t6_ack", 32'(ack), 32'b00001);
        req = '0;
        tick(1);
        chk("t6_valid", 32'(out_valid), 1);
        chk("t6_data", 32'(out_data), 2);
        tick(1);
        chk("t6_idle", 32'(out_valid), 0);
        tick(2);
        chk("t6_stay_idle", 32'(out_valid), 0);
        chk("t6_stay_ack", 32'(ack), 0);

        chk("sb_drained", 32'(q.size()), 0);
        chk("sel_range", 32'(sel_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
